sent_tx_serial_sched: RTL
=========================

Name: sent_tx_serial_sched

Overview:
- Round-robin scheduler for the SENT TX slow (serial) channel.
- NUM_REQ requesters each post one serial message: id, 16-bit data field, config bit.
- Grants one message at a time and drives enable/id/data_bit_field/config_bit/channel_format of the TX core, holding them stable for a whole serial message.
- Counts completed fast-channel frames from the TX core (16 short serial, 18 enhanced), then acks the requester and re-arbitrates.

Parameters:
- NUM_REQ, 4, number of message requesters (2..8).
- TIMEOUT_CYC, 65535, max clk_tx cycles between frame_done pulses before abort (16-bit).

Ports:
- clk_tx  in  1  clock.
- reset_tx  in  1  synchronous, active-high reset.
- sched_en  in  1  allow new grants.
- channel_format_in  in  1  0 short serial, 1 enhanced serial.
- req  in  NUM_REQ  level request, held until ack.
- req_id  in  8*NUM_REQ  id per requester (slice i = bits 8i+7:8i).
- req_data  in  16*NUM_REQ  data field per requester.
- req_cfg  in  NUM_REQ  enhanced config bit per requester.
- frame_done  in  1  one-cycle pulse per completed TX frame.
- ack  out  NUM_REQ  one-cycle pulse, message fully sent.
- enable  out  1  to TX core.
- channel_format  out  1  latched format to TX core.
- id  out  8  to TX core.
- data_bit_field  out  16  to TX core.
- config_bit  out  1  to TX core.
- busy  out  1  message in progress.
- grant_idx  out  $clog2(NUM_REQ)  current/last granted requester.
- timeout_err  out  1  one-cycle pulse on abort.

Behaviour:
- One clock (clk_tx); reset_tx is synchronous and active-high.
- Reset: all outputs 0, rr_ptr=0, frame_cnt=0, timer=0, state IDLE.
- States: IDLE, SEND.
- Arbitration:
  - Search starts at rr_ptr and wraps; first i with req[i]=1 wins.
  - Evaluated in IDLE when sched_en=1, and in SEND on the completing cycle.
- Grant (registered, takes effect next cycle):
  - Latch req_id/req_data/req_cfg slice and channel_format_in into the outputs.
  - grant_idx=i, enable=1, busy=1, frame_cnt=0, timer=0, state SEND.
- SEND:
  - Output registers frozen; input changes ignored (including channel_format_in and req dropping).
  - frame_done: frame_cnt+1, timer=0. Otherwise timer+1.
  - LAST = 15 if latched format=0, 17 if 1.
- Completion (frame_done with frame_cnt==LAST):
  - ack[grant_idx]=1 for one cycle; rr_ptr=grant_idx+1 mod NUM_REQ.
  - Same cycle, if sched_en and any req excluding grant_idx, re-arbitrate from the new rr_ptr: zero-gap back-to-back, enable stays 1, new fields load on the next edge.
  - Else state IDLE, enable=0, busy=0.
- Timeout (timer==TIMEOUT_CYC-1 without frame_done):
  - timeout_err pulse, no ack, rr_ptr=grant_idx+1, state IDLE, enable=0.
  - Requester stays pending.
- sched_en low mid-message: current message completes normally; no new grant afterwards.
- frame_done in IDLE ignored.
- A requester re-asserting immediately after its ack has lowest priority (fairness).
- Simultaneous completion and timeout: completion wins.
- Widths: frame_cnt 5 bits, timer 16 bits; no wrap possible within legal ranges.

Decomposition:
- Shared package sent_pkg:
  - SHORT_SERIAL_FRAMES=16, ENH_SERIAL_FRAMES=18.
  - State typedef (IDLE, SEND).
  - Format constants FMT_SHORT=0, FMT_ENH=1.
- Sub-module sent_rr_arbiter: combinational rotating-priority find-first.
  - Inputs: req vector, rr_ptr, exclude mask.
  - Outputs: valid, index.

Test Plan:
- Single request: req=4'b0010, id=8'h5A, data=16'h1234, format 0; 16 frame_done pulses → enable 1 from cycle after grant, ack[1] pulse only after 16th pulse, enable 0 next cycle.
- Enhanced count: format 1, req[0], cfg=1 → config_bit=1 throughout, ack[0] after exactly 18 frame_done; 17 pulses give no ack.
- Round-robin: req=4'b1111 held → grant order 0,1,2,3,0, enable never drops between messages, each ack aligned with its completing frame_done.
- Mid-message change: toggle channel_format_in and req_data[2] during message 2 → outputs unchanged until next grant; frame target stays as latched.
- Timeout: TIMEOUT_CYC=100, no frame_done for 100 cycles → timeout_err pulse, no ack, next grant goes to the next index.
- Reset mid-SEND at frame 7 → next cycle all outputs 0, rr_ptr 0; after release with req=4'b0001 a fresh 16-frame message runs.

Source files
------------

// File: rtl/sent_pkg.sv
`default_nettype none
// ============================================================================
// sent_pkg : shared constants and types for the SENT TX serial scheduler
// Rev 1.0  : initial release
// ============================================================================
package sent_pkg;

  localparam int SHORT_SERIAL_FRAMES = 16;
  localparam int ENH_SERIAL_FRAMES   = 18;

  localparam logic FMT_SHORT = 1'b0;
  localparam logic FMT_ENH   = 1'b1;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SEND = 1'b1
  } sched_state_e;

  // Index of the frame_done pulse that completes a serial message
  function automatic logic [4:0] last_frame(input logic fmt);
    last_frame = (fmt == FMT_ENH) ? 5'(ENH_SERIAL_FRAMES - 1)
                                  : 5'(SHORT_SERIAL_FRAMES - 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/sent_rr_arbiter.sv
`default_nettype none
// ============================================================================
// sent_rr_arbiter : combinational rotating-priority find-first arbiter
// Rev 1.0         : initial release
// ============================================================================
module sent_rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   rr_ptr,
  input  logic [NUM_REQ-1:0] exclude,
  output logic               valid,
  output logic [IDX_W-1:0]   index
);

  localparam int SUM_W = IDX_W + 1;

  logic [NUM_REQ-1:0]   w_cand;
  logic [2*NUM_REQ-1:0] w_dbl;
  logic [NUM_REQ-1:0]   w_rot;
  logic [SUM_W-1:0]     w_sum;

  assign w_cand = req & ~exclude;
  assign w_dbl  = {w_cand, w_cand};
  // Bit k of w_rot is candidate (rr_ptr + k) mod NUM_REQ
  assign w_rot  = w_dbl[rr_ptr +: NUM_REQ];

  always_comb begin
    valid = 1'b0;
    index = '0;
    w_sum = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!valid && w_rot[k]) begin
        valid = 1'b1;
        w_sum = {1'b0, rr_ptr} + SUM_W'(k);
        if (w_sum >= SUM_W'(NUM_REQ)) begin
          w_sum = w_sum - SUM_W'(NUM_REQ);
        end
        index = w_sum[IDX_W-1:0];
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/sent_tx_serial_sched.sv
`default_nettype none
// ============================================================================
// sent_tx_serial_sched : round-robin scheduler for the SENT TX serial channel
// Rev 1.0              : initial release
// ============================================================================
module sent_tx_serial_sched
  import sent_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int TIMEOUT_CYC = 65535
) (
  input  logic                         clk_tx,
  input  logic                         reset_tx,
  input  logic                         sched_en,
  input  logic                         channel_format_in,
  input  logic [NUM_REQ-1:0]           req,
  input  logic [8*NUM_REQ-1:0]         req_id,
  input  logic [16*NUM_REQ-1:0]        req_data,
  input  logic [NUM_REQ-1:0]           req_cfg,
  input  logic                         frame_done,
  output logic [NUM_REQ-1:0]           ack,
  output logic                         enable,
  output logic                         channel_format,
  output logic [7:0]                   id,
  output logic [15:0]                  data_bit_field,
  output logic                         config_bit,
  output logic                         busy,
  output logic [$clog2(NUM_REQ)-1:0]   grant_idx,
  output logic                         timeout_err
);

  localparam int          IDX_W    = $clog2(NUM_REQ);
  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYC - 1);

  sched_state_e       state_q, state_d;
  logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [4:0]         frame_cnt_q, frame_cnt_d;
  logic [15:0]        timer_q, timer_d;
  logic [NUM_REQ-1:0] ack_q, ack_d;
  logic               enable_q, enable_d;
  logic               fmt_q, fmt_d;
  logic [7:0]         id_q, id_d;
  logic [15:0]        data_q, data_d;
  logic               cfg_q, cfg_d;
  logic               busy_q, busy_d;
  logic [IDX_W-1:0]   grant_idx_q, grant_idx_d;
  logic               timeout_q, timeout_d;

  logic [IDX_W-1:0]   w_rr_next;
  logic [NUM_REQ-1:0] w_grant_oh;
  logic [IDX_W-1:0]   w_arb_ptr;
  logic [NUM_REQ-1:0] w_excl;
  logic               w_arb_valid;
  logic [IDX_W-1:0]   w_arb_idx;
  logic               w_complete;
  logic               w_timeout;
  logic               w_do_grant;

  assign w_rr_next  = (grant_idx_q == IDX_W'(NUM_REQ - 1)) ? '0 : grant_idx_q + 1'b1;
  assign w_grant_oh = NUM_REQ'(1) << grant_idx_q;

  // In IDLE the requester being acked this cycle still holds req; mask it.
  assign w_arb_ptr  = (state_q == SEND) ? w_rr_next  : rr_ptr_q;
  assign w_excl     = (state_q == SEND) ? w_grant_oh : ack_q;

  sent_rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_arb (
    .req     (req),
    .rr_ptr  (w_arb_ptr),
    .exclude (w_excl),
    .valid   (w_arb_valid),
    .index   (w_arb_idx)
  );

  assign w_complete = (state_q == SEND) && frame_done && (frame_cnt_q == last_frame(fmt_q));
  assign w_timeout  = (state_q == SEND) && !frame_done && (timer_q == TMO_LAST);
  assign w_do_grant = sched_en && w_arb_valid && ((state_q == IDLE) || w_complete);

  always_ff @(posedge clk_tx) begin
    if (reset_tx) begin
      state_q     <= IDLE;
      rr_ptr_q    <= '0;
      frame_cnt_q <= '0;
      timer_q     <= '0;
      ack_q       <= '0;
      enable_q    <= 1'b0;
      fmt_q       <= FMT_SHORT;
      id_q        <= '0;
      data_q      <= '0;
      cfg_q       <= 1'b0;
      busy_q      <= 1'b0;
      grant_idx_q <= '0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      frame_cnt_q <= frame_cnt_d;
      timer_q     <= timer_d;
      ack_q       <= ack_d;
      enable_q    <= enable_d;
      fmt_q       <= fmt_d;
      id_q        <= id_d;
      data_q      <= data_d;
      cfg_q       <= cfg_d;
      busy_q      <= busy_d;
      grant_idx_q <= grant_idx_d;
      timeout_q   <= timeout_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (w_do_grant) state_d = SEND;
      SEND: begin
        if (w_complete) begin
          if (!w_do_grant) state_d = IDLE;
        end else if (w_timeout) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    rr_ptr_d    = rr_ptr_q;
    frame_cnt_d = frame_cnt_q;
    timer_d     = timer_q;
    ack_d       = '0;
    enable_d    = enable_q;
    fmt_d       = fmt_q;
    id_d        = id_q;
    data_d      = data_q;
    cfg_d       = cfg_q;
    busy_d      = busy_q;
    grant_idx_d = grant_idx_q;
    timeout_d   = 1'b0;

    if (state_q == SEND) begin
      if (frame_done) begin
        frame_cnt_d = frame_cnt_q + 5'd1;
        timer_d     = '0;
      end else begin
        timer_d     = timer_q + 16'd1;
      end

      if (w_complete) begin
        ack_d    = w_grant_oh;
        rr_ptr_d = w_rr_next;
        enable_d = 1'b0;
        busy_d   = 1'b0;
      end else if (w_timeout) begin
        timeout_d = 1'b1;
        rr_ptr_d  = w_rr_next;
        enable_d  = 1'b0;
        busy_d    = 1'b0;
        timer_d   = '0;
      end
    end

    // A grant in the completing cycle overrides the drop of enable/busy
    if (w_do_grant) begin
      fmt_d       = channel_format_in;
      id_d        = req_id[{w_arb_idx, 3'b000} +: 8];
      data_d      = req_data[{w_arb_idx, 4'b0000} +: 16];
      cfg_d       = req_cfg[w_arb_idx];
      grant_idx_d = w_arb_idx;
      enable_d    = 1'b1;
      busy_d      = 1'b1;
      frame_cnt_d = '0;
      timer_d     = '0;
    end
  end

  assign ack            = ack_q;
  assign enable         = enable_q;
  assign channel_format = fmt_q;
  assign id             = id_q;
  assign data_bit_field = data_q;
  assign config_bit     = cfg_q;
  assign busy           = busy_q;
  assign grant_idx      = grant_idx_q;
  assign timeout_err    = timeout_q;

endmodule
`default_nettype wire
